uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of receive byte entries; power of two, at least 2.
REQ-002 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-003 Port rstn, input, 1, reset, synchronous and active-low.
REQ-004 Port en, input, 1, receiver enable; low holds the FSM in IDLE and stops the baud tick counter.
REQ-005 Port div, input, 16, oversample divisor; one oversample tick every div+1 clocks, 16 ticks per bit.
REQ-006 Port rx, input, 1, asynchronous serial line, idle high.
REQ-007 Port rx_data, output, 8, byte at the FIFO head.
REQ-008 Port rx_valid, output, 1, FIFO not empty.
REQ-009 Port rx_ready, input, 1, consumer pop strobe; a pop occurs when rx_valid and rx_ready are both high.
REQ-010 Port busy, output, 1, FSM not in IDLE.
REQ-011 Port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-012 Port overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-014 Tick counter: counts 0..div; tick is asserted in the cycle it equals div, then it wraps to 0. It is forced to 0 while in IDLE or while en=0.
REQ-015 Phase counter, 4 bits, advances on each tick and wraps 15->0; each wrap ends one bit period. It is cleared on IDLE exit.
REQ-016 Sample vote = majority of rxs captured on the ticks at phase 7, 8 and 9; the vote is resolved at the phase-9 tick.
REQ-017 FSM states: IDLE, START, DATA, STOP, BRK.
- IDLE: rxs=0 and en=1 -> START.
- START: vote 0 -> DATA; vote 1 -> IDLE (false start, nothing else happens).
- DATA: 8 votes, LSB first, one per bit period. After the 8th vote -> STOP at the next phase wrap.
- STOP: vote 1 -> push byte, then IDLE in the same cycle. Vote 0 -> frame_err pulse, no push, -> BRK.
- BRK: stays until rxs=1, then -> IDLE.
REQ-018 STOP returns to IDLE at the mid-bit vote, not at the end of the bit, so a following start edge is caught early enough to resync.
REQ-019 The push takes effect so that rx_valid rises exactly 1 clock after the phase-9 tick of the stop bit (when the FIFO was empty).
REQ-020 FIFO: rx_data shows the head combinationally from the storage register. Bytes come out in first-in first-out order.
REQ-021 Full, push only: byte discarded, FIFO contents unchanged, overrun pulses in the same cycle as the push attempt.
REQ-022 Full, push and pop in the same cycle: both are performed; no overrun.
REQ-023 Empty, pop only: ignored (rx_valid is already 0).
REQ-024 Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by a count register of width clog2(FIFO_DEPTH)+1.
REQ-025 en falling mid-frame: the FSM goes to IDLE on the next clock, the partial byte is discarded, and the FIFO is retained.
REQ-026 A change of div takes effect at the next tick-counter wrap. If the counter already exceeds the new div, it wraps at 0xFFFF.

Reset
REQ-027 rstn=0 at a clock edge sets the following: FSM=IDLE, all counters=0, FIFO empty, rx_valid=0, rx_data=0, busy=0, frame_err=0, overrun=0, synchronizer=1.
REQ-028 A reset asserted mid-frame aborts the frame. No partial byte is pushed after reset release.

Verification
REQ-029 en=1, div=0, 0x55 sent at 16 clk/bit -> rx_data=0x55 and rx_valid=1 exactly 1 clk after the stop phase-9 tick; busy=0 in that cycle.
REQ-030 div=3, rx low for 20 clks then high -> no START->DATA transition, rx_valid stays 0, frame_err=0.
REQ-031 div=0, 0xA5 sent with stop bit=0, line held low 40 clks -> frame_err single pulse, FSM in BRK, no push; rx high, then byte 0x3C sent -> rx_data=0x3C.
REQ-032 FIFO_DEPTH=4, rx_ready=0, bytes 0x01..0x05 sent -> exactly one overrun pulse (on 0x05); popping yields 0x01,0x02,0x03,0x04, then rx_valid=0.
REQ-033 FIFO holds 4 entries, a 5th byte completes with rx_ready=1 in the same cycle -> no overrun; output order is preserved with the new byte last.
REQ-034 rstn pulsed low during data bit 4 of 0xFF -> all outputs at reset values; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 16x oversampled start/data/stop detection with
// mid-bit majority voting, feeding a small byte FIFO with overrun/frame error pulses.
module uart_rx_frontend #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [15:0] div,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_sync1;
  logic             r_rxs;
  logic [15:0]      r_tickCnt;
  logic [3:0]       r_phase;
  logic             r_s7;
  logic             r_s8;
  logic [3:0]       r_bitCnt;
  logic [7:0]       r_shift;
  logic             w_tick;
  logic             w_mid;
  logic             w_phaseWrap;
  logic             w_vote;
  logic             w_push;
  logic             w_frameErr;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wrPtr;
  logic [PtrW-1:0]  r_rdPtr;
  logic [CntW-1:0]  r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_write;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  // A counter left above a newly lowered div runs on to 0xFFFF and wraps naturally.
  assign w_tick      = en && (r_state != IDLE) && (r_tickCnt == div);
  assign w_mid       = w_tick && (r_phase == 4'd9);
  assign w_phaseWrap = w_tick && (r_phase == 4'd15);
  assign w_vote      = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

  always_ff @(posedge clk) begin
    if (!rstn || !en || r_state == IDLE) begin
      r_tickCnt <= '0;
    end else if (r_tickCnt == div) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_phase  <= '0;
      r_s7     <= 1'b1;
      r_s8     <= 1'b1;
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else if (r_state == IDLE) begin
      r_phase  <= '0;
      r_bitCnt <= '0;
    end else if (w_tick) begin
      r_phase <= r_phase + 4'd1;
      if (r_phase == 4'd7) r_s7 <= r_rxs;
      if (r_phase == 4'd8) r_s8 <= r_rxs;
      if (w_mid && r_state == DATA) begin
        r_shift  <= {w_vote, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // STOP leaves at its mid-bit vote so the next start edge is never missed.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_frameErr  = 1'b0;
    if (!en) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (!r_rxs) w_nextState = START;
        START: if (w_mid) w_nextState = w_vote ? IDLE : DATA;
        DATA:  if (r_bitCnt == 4'd8 && w_phaseWrap) w_nextState = STOP;
        STOP: begin
          if (w_mid) begin
            if (w_vote) begin
              w_push      = 1'b1;
              w_nextState = IDLE;
            end else begin
              w_frameErr  = 1'b1;
              w_nextState = BRK;
            end
          end
        end
        BRK:     if (r_rxs) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign frame_err = w_frameErr;

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_full   = (r_count == CntW'(FIFO_DEPTH));
  assign rx_valid = (r_count != '0);
  assign w_pop    = rx_valid && rx_ready;
  assign w_write  = w_push && (!w_full || w_pop);
  assign overrun  = w_push && w_full && !w_pop;
  assign rx_data  = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_wrPtr] <= r_shift;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: frame timing, false start, break,
// FIFO full/overrun behaviour, enable drop and mid-frame reset.
module tb_uart_rx_frontend;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div = 16'd0;
  logic        rx = 1'b1;
  logic        rxReady = 1'b0;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        busy;
  logic        frameErr;
  logic        overrun;

  typedef struct {
    logic [7:0] txByte;
    int         expOverruns;
    logic       expValid;
    logic [7:0] expHead;
  } fillVec_t;

  fillVec_t   fillTable [5];
  logic [7:0] drainTable [4];

  int   checks = 0;
  int   passes = 0;
  int   cycleCnt = 0;
  int   frameStart = 0;
  int   riseCycle = -1;
  int   frameErrCount = 0;
  int   overrunCount = 0;
  int   base = 0;
  logic prevValid = 1'b0;
  logic busyAtRise = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frontend #(.FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .div(div),
    .rx(rx),
    .rx_data(rxData),
    .rx_valid(rxValid),
    .rx_ready(rxReady),
    .busy(busy),
    .frame_err(frameErr),
    .overrun(overrun)
  );

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin
    if (frameErr) frameErrCount++;
    if (overrun) overrunCount++;
    if (rxValid && !prevValid) begin
      riseCycle  = cycleCnt;
      busyAtRise = busy;
    end
    prevValid = rxValid;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Edge numbering: the posedge before rx falls is edge 0 of the frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int cpb, input int extraLow);
    @(posedge clk);
    #1;
    frameStart = cycleCnt;
    rx = 1'b0;
    repeat (cpb) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
    rx = stopBit;
    repeat (cpb) @(posedge clk);
    #1;
    if (extraLow > 0) begin
      repeat (extraLow) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic popByte(input logic [7:0] expected, input string name);
    @(negedge clk);
    checkOutput({name, " valid"}, 32'(rxValid), 1);
    checkOutput({name, " data"}, 32'(rxData), 32'(expected));
    rxReady = 1'b1;
    @(posedge clk);
    #1;
    rxReady = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fillTable[0] = '{8'h01, 0, 1'b1, 8'h01};
    fillTable[1] = '{8'h02, 0, 1'b1, 8'h01};
    fillTable[2] = '{8'h03, 0, 1'b1, 8'h01};
    fillTable[3] = '{8'h04, 0, 1'b1, 8'h01};
    fillTable[4] = '{8'h05, 1, 1'b1, 8'h01};
    drainTable   = '{8'h01, 8'h02, 8'h03, 8'h04};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rx_valid", 32'(rxValid), 0);
    checkOutput("reset rx_data", 32'(rxData), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset frame_err", 32'(frameErr), 0);
    checkOutput("reset overrun", 32'(overrun), 0);
    rstn = 1'b1;
    en   = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Stop-bit vote lands in the cycle after edge 156, so valid is seen after edge 157.
    applyStimulus(8'h55, 1'b1, 16, 0);
    checkOutput("0x55 valid latency", riseCycle - frameStart, 157);
    checkOutput("0x55 busy at valid", 32'(busyAtRise), 0);
    popByte(8'h55, "0x55");
    @(negedge clk);
    checkOutput("empty after 0x55", 32'(rxValid), 0);

    div  = 16'd3;
    base = frameErrCount;
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    checkOutput("false start busy", 32'(busy), 1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("false start back idle", 32'(busy), 0);
    checkOutput("false start rx_valid", 32'(rxValid), 0);
    checkOutput("false start frame_err", frameErrCount - base, 0);
    div = 16'd0;

    base = frameErrCount;
    applyStimulus(8'hA5, 1'b0, 16, 40);
    @(negedge clk);
    checkOutput("break busy", 32'(busy), 1);
    checkOutput("break frame_err pulses", frameErrCount - base, 1);
    checkOutput("break rx_valid", 32'(rxValid), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("break released", 32'(busy), 0);
    applyStimulus(8'h3C, 1'b1, 16, 0);
    popByte(8'h3C, "after break");

    base = overrunCount;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(fillTable[i].txByte, 1'b1, 16, 0);
      @(negedge clk);
      checkOutput($sformatf("fill %0d overruns", i), overrunCount - base, fillTable[i].expOverruns);
      checkOutput($sformatf("fill %0d valid", i), 32'(rxValid), 32'(fillTable[i].expValid));
      checkOutput($sformatf("fill %0d head", i), 32'(rxData), 32'(fillTable[i].expHead));
    end
    for (int i = 0; i < 4; i++) popByte(drainTable[i], $sformatf("drain %0d", i));
    @(negedge clk);
    checkOutput("drained valid", 32'(rxValid), 0);

    @(negedge clk);
    rxReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rxReady = 1'b0;
    @(negedge clk);
    checkOutput("empty pop valid", 32'(rxValid), 0);

    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 16, 0);
    base = overrunCount;
    fork
      applyStimulus(8'h14, 1'b1, 16, 0);
      begin
        repeat (157) @(posedge clk);
        #1;
        checkOutput("full push head", 32'(rxData), 32'h10);
        rxReady = 1'b1;
        @(posedge clk);
        #1;
        rxReady = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("push+pop overrun", overrunCount - base, 0);
    for (int i = 0; i < 4; i++) popByte(8'h11 + 8'(i), $sformatf("push+pop drain %0d", i));
    @(negedge clk);
    checkOutput("push+pop drained", 32'(rxValid), 0);

    applyStimulus(8'h42, 1'b1, 16, 0);
    fork
      applyStimulus(8'h00, 1'b1, 16, 0);
      begin
        repeat (60) @(posedge clk);
        #1;
        checkOutput("en drop busy before", 32'(busy), 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("en drop busy after", 32'(busy), 0);
      end
    join
    en = 1'b1;
    repeat (4) @(posedge clk);
    popByte(8'h42, "en drop retained");
    @(negedge clk);
    checkOutput("en drop no partial", 32'(rxValid), 0);

    applyStimulus(8'h77, 1'b1, 16, 0);
    fork
      applyStimulus(8'hFF, 1'b1, 16, 0);
      begin
        repeat (88) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid reset rx_valid", 32'(rxValid), 0);
        checkOutput("mid reset rx_data", 32'(rxData), 0);
        checkOutput("mid reset busy", 32'(busy), 0);
        checkOutput("mid reset frame_err", 32'(frameErr), 0);
        checkOutput("mid reset overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("after reset no push", 32'(rxValid), 0);
    checkOutput("after reset idle", 32'(busy), 0);
    applyStimulus(8'h81, 1'b1, 16, 0);
    popByte(8'h81, "after reset 0x81");
    @(negedge clk);
    checkOutput("final empty", 32'(rxValid), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
